// File: rtl/branch_resolve_pkg.sv
// Shared types and defaults for the branch resolve block: FSM encoding,
// E/M pipeline register layouts and parameter defaults.
package branch_resolve_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } br_state_e;

  localparam logic [31:0] FT_OFS_DEF = 32'd4;
  localparam int          CNT_W_DEF  = 32;

  // Recovery counter: loaded on the error cycle, one extra flush cycle follows.
  localparam int              REC_W   = 2;
  localparam logic [REC_W-1:0] REC_LEN = REC_W'(1);
  localparam logic [REC_W-1:0] REC_ONE = REC_W'(1);

  typedef struct packed {
    logic        branch;
    logic        pred_take;
    logic [31:0] pc;
    logic [31:0] target;
  } e_reg_t;

  typedef struct packed {
    logic        branch;
    logic        pred_take;
    logic        actual_take;
    logic [31:0] pc;
    logic [31:0] target;
  } m_reg_t;

endpackage

// File: rtl/branch_resolve_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_resolve.sv
// Resolves conditional branches in M: detects mispredicts, redirects fetch,
// flushes D/E for two cycles and keeps branch/mispredict statistics.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter logic [31:0] FT_OFS = FT_OFS_DEF,
  parameter int          CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branchD,
  input  logic             pred_takeD,
  input  logic [31:0]      pcD,
  input  logic [31:0]      targetD,
  input  logic             stallE,
  input  logic             stallM,
  input  logic             flushE_in,
  input  logic             actual_takeE,
  output logic             branchM,
  output logic             actual_takeM,
  output logic [31:0]      pcM,
  output logic             errorM,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flushD_o,
  output logic             flushE_o,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  e_reg_t           e_q, e_d;
  m_reg_t           m_q, m_d;
  br_state_e        state_q, state_d;
  logic [REC_W-1:0] rec_cnt_q, rec_cnt_d;
  logic             err, flush, br_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q       <= '0;
      m_q       <= '0;
      state_q   <= IDLE;
      rec_cnt_q <= '0;
    end else begin
      e_q       <= e_d;
      m_q       <= m_d;
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    case (state_q)
      IDLE: if (err) begin
        state_d   = RECOVER;
        rec_cnt_d = REC_LEN;
      end
      RECOVER: begin
        rec_cnt_d = rec_cnt_q - REC_ONE;
        if (rec_cnt_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A stalled M branch is evaluated only once the stall releases.
  always_comb begin
    err         = m_q.branch & (m_q.pred_take != m_q.actual_take) &
                  (state_q == IDLE) & ~stallM;
    flush       = err | (state_q == RECOVER);
    redirect_pc = '0;
    if (err) redirect_pc = m_q.actual_take ? m_q.target : (m_q.pc + FT_OFS);
  end

  always_comb begin
    e_d = e_q;
    if (flushE_in || flush) e_d = '0;
    else if (!stallE)       e_d = '{branchD, pred_takeD, pcD, targetD};
  end

  always_comb begin
    m_d = m_q;
    if (err) m_d = '0;
    else if (!stallM) begin
      if (stallE) m_d = '0;
      else        m_d = '{e_q.branch, e_q.pred_take, actual_takeE, e_q.pc, e_q.target};
    end
  end

  assign br_inc         = m_q.branch & ~stallM & (state_q == IDLE);
  assign branchM        = m_q.branch;
  assign actual_takeM   = m_q.actual_take;
  assign pcM            = m_q.pc;
  assign errorM         = err;
  assign redirect_valid = err;
  assign flushD_o       = flush;
  assign flushE_o       = flush;

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk (clk),
    .rst (rst),
    .inc (br_inc),
    .cnt (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mis_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err),
    .cnt (mispred_cnt)
  );

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios plus random traffic against a
// transaction-level reference model.
module tb_branch_resolve;

  localparam int          CW  = 4;
  localparam int          SAT = 15;
  localparam logic [31:0] FT  = 32'd4;

  logic          clk = 1'b0;
  logic          rst, branchD, pred_takeD, stallE, stallM, flushE_in, actual_takeE;
  logic [31:0]   pcD, targetD;
  logic          branchM, actual_takeM, errorM, redirect_valid, flushD_o, flushE_o;
  logic [31:0]   pcM, redirect_pc;
  logic [CW-1:0] branch_cnt, mispred_cnt;

  always #5 clk = ~clk;

  branch_resolve #(.FT_OFS(FT), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .branchD        (branchD),
    .pred_takeD     (pred_takeD),
    .pcD            (pcD),
    .targetD        (targetD),
    .stallE         (stallE),
    .stallM         (stallM),
    .flushE_in      (flushE_in),
    .actual_takeE   (actual_takeE),
    .branchM        (branchM),
    .actual_takeM   (actual_takeM),
    .pcM            (pcM),
    .errorM         (errorM),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flushD_o       (flushD_o),
    .flushE_o       (flushE_o),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one in-flight instruction per slot, plus a count of
  // remaining recovery cycles and plain integer statistics.
  typedef struct {
    bit          v;
    bit          pred;
    bit          act;
    logic [31:0] pc;
    logic [31:0] tgt;
  } slot_t;

  slot_t slot_e, slot_m;
  int    rec_left = 0;
  int    bc = 0, mc = 0;
  bit    init = 0;

  task automatic step(input bit bD, input bit pT, input logic [31:0] pc, input logic [31:0] tg,
                      input bit sE, input bit sM, input bit fE, input bit aT, input bit r);
    bit          x_err, x_fl;
    logic [31:0] x_rpc;
    slot_t       nxt_m;
    branchD = bD; pred_takeD = pT; pcD = pc; targetD = tg;
    stallE = sE; stallM = sM; flushE_in = fE; actual_takeE = aT; rst = r;
    #1;
    x_err = slot_m.v && (slot_m.pred != slot_m.act) && (rec_left == 0) && !sM;
    x_fl  = x_err || (rec_left > 0);
    x_rpc = !x_err ? 32'd0 : (slot_m.act ? slot_m.tgt : slot_m.pc + FT);
    if (init) begin
      chk("branchM", branchM, slot_m.v);
      if (slot_m.v) begin
        chk("actual_takeM", actual_takeM, slot_m.act);
        chk("pcM", pcM, slot_m.pc);
      end
      chk("errorM", errorM, x_err);
      chk("redirect_valid", redirect_valid, x_err);
      chk("redirect_pc", redirect_pc, x_rpc);
      chk("flushD_o", flushD_o, x_fl);
      chk("flushE_o", flushE_o, x_fl);
      chk("branch_cnt", branch_cnt, bc);
      chk("mispred_cnt", mispred_cnt, mc);
    end
    @(posedge clk);
    if (r) begin
      slot_e = '{0, 0, 0, 0, 0};
      slot_m = '{0, 0, 0, 0, 0};
      rec_left = 0; bc = 0; mc = 0; init = 1;
    end else begin
      if (slot_m.v && !sM && rec_left == 0 && bc < SAT) bc++;
      if (x_err && mc < SAT) mc++;
      nxt_m = slot_m;
      if (x_err) nxt_m.v = 0;
      else if (!sM) begin
        if (sE) nxt_m.v = 0;
        else    nxt_m = '{slot_e.v, slot_e.pred, aT, slot_e.pc, slot_e.tgt};
      end
      slot_m = nxt_m;
      if (fE || x_fl) slot_e.v = 0;
      else if (!sE)   slot_e = '{bD, pT, 0, pc, tg};
      if (x_err)             rec_left = 1;
      else if (rec_left > 0) rec_left--;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1; branchD = 0; pred_takeD = 0; pcD = 0; targetD = 0;
    stallE = 0; stallM = 0; flushE_in = 0; actual_takeE = 0;
    @(negedge clk);
    do_reset();
    chk("rst_branchM", branchM, 0);
    chk("rst_pcM", pcM, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_flushD", flushD_o, 0);
    chk("rst_bcnt", branch_cnt, 0);

    // correct taken branch
    step(1, 1, 32'h100, 32'h200, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("tk_branchM", branchM, 1);
    chk("tk_errorM", errorM, 0);
    chk("tk_pcM", pcM, 32'h100);
    idle(1);
    chk("tk_bcnt", branch_cnt, 1);

    // not-taken mispredict
    do_reset();
    step(1, 1, 32'h100, 32'h200, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("nt_errorM", errorM, 1);
    chk("nt_redirect_pc", redirect_pc, 32'h104);
    chk("nt_flushD", flushD_o, 1);
    chk("nt_flushE", flushE_o, 1);
    idle(1);
    chk("nt_rec_flushD", flushD_o, 1);
    chk("nt_rec_errorM", errorM, 0);
    idle(1);
    chk("nt_done_flushE", flushE_o, 0);
    chk("nt_mcnt", mispred_cnt, 1);

    // taken mispredict with a second mispredicting branch behind it in E
    do_reset();
    step(1, 0, 32'h300, 32'h400, 0, 0, 0, 0, 0);
    step(1, 1, 32'h500, 32'h600, 0, 0, 0, 1, 0);
    chk("tm_errorM", errorM, 1);
    chk("tm_redirect_pc", redirect_pc, 32'h400);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("tm_mcnt", mispred_cnt, 1);
    chk("tm_bcnt", branch_cnt, 1);

    // stall a mispredicting branch in M for 3 cycles
    do_reset();
    step(1, 1, 32'h700, 32'h800, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("st_errorM_held", errorM, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    chk("st_mcnt", mispred_cnt, 1);
    chk("st_bcnt", branch_cnt, 1);

    // counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 1, 32'h1000 + 32'(i * 4), 32'h2000, 0, 0, 0, 1, 0);
    idle(2);
    chk("sat_bcnt", branch_cnt, 15);

    // reset in RECOVER
    do_reset();
    step(1, 1, 32'h100, 32'h200, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("rr_in_recover", flushD_o, 1);
    do_reset();
    chk("rr_branchM", branchM, 0);
    chk("rr_errorM", errorM, 0);
    chk("rr_redirect_pc", redirect_pc, 0);
    chk("rr_flushD", flushD_o, 0);
    chk("rr_flushE", flushE_o, 0);
    chk("rr_mcnt", mispred_cnt, 0);

    // random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
           $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1), $urandom_range(0, 63) == 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter FT_OFS, default 32'd4, the fall-through offset added to the branch PC on a not-taken redirect.
REQ-002 SHALL have parameter CNT_W, default 32, the width of the statistics counters.
REQ-003 SHALL have ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- branchD  in  1  the instruction in D is a conditional branch.
- pred_takeD  in  1  predictor output for the D instruction.
- pcD  in  32  PC of the D instruction.
- targetD  in  32  computed branch target of the D instruction.
- stallE  in  1  hold the E-stage register.
- stallM  in  1  hold the M-stage register.
- flushE_in  in  1  external clear of the E stage (hazard unit).
- actual_takeE  in  1  condition result from the E-stage comparator.
- branchM  out  1  M holds a valid branch.
- actual_takeM  out  1  resolved direction in M.
- pcM  out  32  PC of the M instruction.
- errorM  out  1  misprediction detected in M.
- redirect_valid  out  1  fetch must load redirect_pc.
- redirect_pc  out  32  corrected fetch address.
- flushD_o  out  1  clear the D stage.
- flushE_o  out  1  clear the E stage.
- branch_cnt  out  CNT_W  resolved-branch count.
- mispred_cnt  out  CNT_W  misprediction count.

Function
REQ-004 SHALL capture {branchD, pred_takeD, pcD, targetD} into the E register on each clk when stallE=0.
- The E register SHALL clear (branch=0) when flushE_in=1 or flushE_o=1; clear takes priority over stall.
REQ-005 SHALL capture the E contents plus actual_takeE into the M register when stallM=0.
- When stallE=1 and stallM=0, the M register SHALL load a bubble (branch=0).
- The M register SHALL clear on the cycle after errorM=1.
REQ-006 branchM, actual_takeM and pcM SHALL be driven directly from the M register, giving 2-cycle latency from D to M with no stalls.
REQ-007 errorM SHALL equal branchM & (pred_takeM != actual_takeM) & (state==IDLE) & ~stallM, and SHALL be combinational from M-register state.
REQ-008 redirect_valid SHALL equal errorM.
- redirect_pc = targetM when actual_takeM=1, else pcM+FT_OFS (modulo 2^32).
- redirect_pc = 0 when redirect_valid=0.
REQ-009 flushD_o and flushE_o SHALL assert in the errorM cycle and in every RECOVER cycle.
REQ-010 FSM states:
- IDLE -> RECOVER on errorM=1; RECOVER_CNT loads 1.
- RECOVER decrements RECOVER_CNT each cycle and returns to IDLE when RECOVER_CNT=0, giving exactly 2 flush cycles in total.
- No errorM is generated in RECOVER.
REQ-011 branch_cnt SHALL increment by 1 each cycle where branchM=1, ~stallM and state==IDLE; mispred_cnt SHALL increment by 1 each cycle where errorM=1.
- Both counters saturate at all-ones.
REQ-012 A stalled M (stallM=1) with branchM=1 SHALL neither count nor flag; it is evaluated once, on the cycle the stall is released.
REQ-013 Simultaneous events:
- errorM SHALL dominate flushE_in for the redirect.
- A mispredict and an external flush in the same cycle SHALL produce one redirect only.

Reset
REQ-014 On rst=1 at posedge clk:
- E/M registers clear (branch=0, PCs=0, pred/actual=0).
- FSM goes to IDLE; counters go to 0.
REQ-015 All outputs SHALL be 0 in the cycle following reset; reset asserted mid-RECOVER SHALL abandon recovery immediately.

Structure
REQ-016 The shared package SHALL hold the FSM state encoding (IDLE=1'b0, RECOVER=1'b1), FT_OFS default and CNT_W default.
REQ-017 The saturating counter SHALL be one sub-module, sat_counter, instantiated twice.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Correct taken: branchD=1, pred_takeD=1, actual_takeE=1, pcD=0x100, targetD=0x200 -> 2 cycles later branchM=1, errorM=0, branch_cnt=1.
- Not-taken mispredict: pred=1, actual=0, pcD=0x100 -> errorM=1, redirect_pc=0x104, flushD_o=flushE_o=1 for 2 cycles, mispred_cnt=1.
- Taken mispredict: pred=0, actual=1, targetD=0x400 -> redirect_pc=0x400; a second mispredicting branch already in E is cleared and never flags.
- Stall: stallM=1 for 3 cycles with a mispredicting branch in M -> errorM=0 during the stall, one errorM on release, counters +1 each.
- Saturation and reset: with CNT_W=4 and 20 branches, branch_cnt holds at 15; rst during RECOVER -> next cycle all outputs 0, state IDLE.
